ram_stream_reader: RTL and testbench



---
 rtl/ram_stream_reader.sv | 184 ++++++++++++++++++
 tb/tb_ram_stream_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: burst read engine for a RAM with an asynchronous read port.
// A command (start address, length) walks rd_addr through sequential words. Each
// word is captured into a 2-entry output FIFO and presented as a valid/ready
// stream with last-beat marking. The second FIFO slot lets a word be read in the
// same cycle the consumer pops, so a continuously ready consumer sees one beat per
// cycle. lengthWidth must be at least addressWidth+1 so a full-depth burst fits.
module ram_stream_reader #(
  parameter int addressWidth = 6,
  parameter int dataWidth    = 32,
  parameter int lengthWidth  = 7
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [addressWidth-1:0] cmd_addr,
  input  logic [lengthWidth-1:0]  cmd_length,
  output logic [addressWidth-1:0] rd_addr,
  input  logic [dataWidth-1:0]    rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [dataWidth-1:0]    out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [addressWidth-1:0] ADDR_ONE = {{(addressWidth-1){1'b0}}, 1'b1};
  localparam logic [addressWidth-1:0] ADDR_ZERO = {addressWidth{1'b0}};
  localparam logic [lengthWidth-1:0]  LEN_ONE  = {{(lengthWidth-1){1'b0}}, 1'b1};
  localparam logic [lengthWidth-1:0]  LEN_ZERO = {lengthWidth{1'b0}};
  localparam logic [dataWidth-1:0]    DATA_ZERO = {dataWidth{1'b0}};

  state_t                  state_q, state_d;
  logic [addressWidth-1:0] rd_addr_q, rd_addr_d;
  logic [lengthWidth-1:0]  remaining_q, remaining_d;
  logic [1:0]              occ_q, occ_d;
  logic [dataWidth-1:0]    data0_q, data0_d, data1_q, data1_d;
  logic                    last0_q, last0_d, last1_q, last1_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic pop_s;
  logic issue_s;
  logic new_last_s;

  // Next-state logic: read issue, output FIFO push/pop and burst FSM.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    remaining_d = remaining_q;
    occ_d       = occ_q;
    data0_d     = data0_q;
    data1_d     = data1_q;
    last0_d     = last0_q;
    last1_d     = last1_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    pop_s      = (occ_q != 2'd0) && out_ready;
    // A read may use a slot that is being freed by a pop in the same cycle.
    issue_s    = (state_q == RUN) && (remaining_q != LEN_ZERO) &&
                 ((occ_q != 2'd2) || pop_s);
    new_last_s = (remaining_q == LEN_ONE);

    if (issue_s) begin
      rd_addr_d   = rd_addr_q + ADDR_ONE;
      remaining_d = remaining_q - LEN_ONE;
    end else begin
      rd_addr_d   = rd_addr_q;
      remaining_d = remaining_q;
    end

    // Slot 0 is always the head; a pop shifts slot 1 forward.
    case ({issue_s, pop_s})
      2'b10: begin
        if (occ_q == 2'd0) begin
          data0_d = rd_data;
          last0_d = new_last_s;
        end else begin
          data1_d = rd_data;
          last1_d = new_last_s;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        data0_d = data1_q;
        last0_d = last1_q;
        occ_d   = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          data0_d = rd_data;
          last0_d = new_last_s;
        end else begin
          data0_d = data1_q;
          last0_d = last1_q;
          data1_d = rd_data;
          last1_d = new_last_s;
        end
      end
      default: begin
        occ_d = occ_q;
      end
    endcase

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          rd_addr_d   = cmd_addr;
          remaining_d = cmd_length;
          busy_d      = 1'b1;
          state_d     = (cmd_length == LEN_ZERO) ? DRAIN : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (issue_s && new_last_s) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        // Finish on the edge that removes the final beat (or at once if empty).
        if ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop_s)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset aborts any burst.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      rd_addr_q   <= ADDR_ZERO;
      remaining_q <= LEN_ZERO;
      occ_q       <= 2'd0;
      data0_q     <= DATA_ZERO;
      data1_q     <= DATA_ZERO;
      last0_q     <= 1'b0;
      last1_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      remaining_q <= remaining_d;
      occ_q       <= occ_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      last0_q     <= last0_d;
      last1_q     <= last1_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rd_addr   = rd_addr_q;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = data0_q;
  // Slot 0 keeps stale contents once empty, so gate last with valid.
  assign out_last  = last0_q & (occ_q != 2'd0);
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: RAM model on the async read port, a table of bursts
// with expected completion timing, and a queue of expected beats per burst.
module tb_ram_stream_reader;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int LW = 7;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_length;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] ram [0:63];

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;
  beat_t exp_q[$];

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    int            mode;      // 0: ready=1, 1: ready 1,0,0,1,0,1..., 2: random
    bit            hold;      // keep cmd_valid high with the next entry's command
    int            exp_done;  // expected done cycle after accept, -1 = unchecked
  } vec_t;
  vec_t vecs[8];

  int n_cmp  = 0;
  int n_fail = 0;

  ram_stream_reader #(.addressWidth(AW), .dataWidth(DW), .lengthWidth(LW)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_length(cmd_length),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  assign rd_data = ram[rd_addr];

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one command, then follows the burst until the done cycle.
  task automatic run_burst(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                           input int mode, input int exp_done, input bit hold,
                           input logic [AW-1:0] nxt_addr, input logic [LW-1:0] nxt_len);
    int            c;
    int            popped;
    int            lasts;
    int            first_c;
    int            occ;
    bit            fin;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [AW-1:0] a;
    logic [AW-1:0] issued;
    logic [5:0]    pat;
    beat_t         b;
    pat = 6'b101001;  // bit c%6 gives 1,0,0,1,0,1
    cmd_valid  = 1'b1;
    cmd_addr   = addr;
    cmd_length = len;
    chk("cmd_ready_before_accept", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < int'(len); i++) begin
      a = addr + AW'(i);
      b.data = ram[a];
      b.last = (i == int'(len) - 1);
      exp_q.push_back(b);
    end
    step();
    if (hold) begin
      cmd_addr   = nxt_addr;
      cmd_length = nxt_len;
    end else begin
      cmd_valid = 1'b0;
    end
    c = 0; popped = 0; lasts = 0; first_c = -1; fin = 1'b0; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0;
    while (!fin && c < 300) begin
      if (mode == 0)      out_ready = 1'b1;
      else if (mode == 1) out_ready = pat[c % 6];
      else                out_ready = 1'($urandom_range(0, 1));
      if (c == 0) begin
        chk("rd_addr_at_accept", {26'd0, rd_addr}, {26'd0, addr});
        chk("no_valid_at_accept", {31'd0, out_valid}, 32'd0);
      end
      if (done) begin
        fin = 1'b1;
      end else begin
        chk("busy_during_burst", {31'd0, busy}, 32'd1);
        chk("cmd_ready_during_burst", {31'd0, cmd_ready}, 32'd0);
        issued = rd_addr - addr;
        occ = int'(issued) - popped;
        chk("occupancy_le_2", {31'd0, occ <= 2}, 32'd1);
        chk("valid_matches_occ", {31'd0, out_valid}, {31'd0, occ != 0});
        if (prev_stall) begin
          chk("stall_valid_held", {31'd0, out_valid}, 32'd1);
          chk("stall_data_held", out_data, prev_data);
          chk("stall_last_held", {31'd0, out_last}, {31'd0, prev_last});
        end
        if (out_valid && out_ready) begin
          if (first_c < 0) first_c = c;
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", out_data, 32'hFFFF_FFFF);
          end else begin
            b = exp_q.pop_front();
            chk("beat_data", out_data, b.data);
            chk("beat_last", {31'd0, out_last}, {31'd0, b.last});
          end
          if (out_last) lasts++;
          popped++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        step();
        c++;
      end
    end
    chk("done_within_budget", {31'd0, fin}, 32'd1);
    if (exp_done >= 0) chk("done_cycle", c, exp_done);
    if (mode == 0 && len != '0) chk("first_beat_cycle", first_c, 1);
    chk("busy_low_at_done", {31'd0, busy}, 32'd0);
    chk("cmd_ready_at_done", {31'd0, cmd_ready}, 32'd1);
    chk("no_valid_at_done", {31'd0, out_valid}, 32'd0);
    chk("no_last_at_done", {31'd0, out_last}, 32'd0);
    chk("all_beats_seen", exp_q.size(), 0);
    chk("beat_count", popped, int'(len));
    chk("last_count", lasts, (len != '0) ? 1 : 0);
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h0000_1000 + 32'(i);
    resetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_length = '0; out_ready = 1'b0;
    step();
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rd_addr", {26'd0, rd_addr}, 32'd0);
    resetn = 1'b1;
    step();

    vecs[0] = '{addr: 6'd4,  len: 7'd3, mode: 0, hold: 1'b0, exp_done: 4};
    vecs[1] = '{addr: 6'd62, len: 7'd4, mode: 0, hold: 1'b0, exp_done: 5};
    vecs[2] = '{addr: 6'd0,  len: 7'd0, mode: 0, hold: 1'b0, exp_done: 1};
    vecs[3] = '{addr: 6'd10, len: 7'd5, mode: 1, hold: 1'b0, exp_done: -1};
    vecs[4] = '{addr: 6'd20, len: 7'd2, mode: 0, hold: 1'b1, exp_done: 3};
    vecs[5] = '{addr: 6'd30, len: 7'd3, mode: 0, hold: 1'b0, exp_done: 4};
    vecs[6] = '{addr: 6'd40, len: 7'd7, mode: 2, hold: 1'b0, exp_done: -1};
    vecs[7] = '{addr: 6'd60, len: 7'd8, mode: 1, hold: 1'b0, exp_done: -1};

    for (int i = 0; i < 8; i++) begin
      if (i == 6) ram[40] = 32'hCAFE_0040;
      run_burst(vecs[i].addr, vecs[i].len, vecs[i].mode, vecs[i].exp_done, vecs[i].hold,
                vecs[(i + 1) % 8].addr, vecs[(i + 1) % 8].len);
      if (!vecs[i].hold) begin
        out_ready = 1'b1;
        step();
        chk("done_single_cycle", {31'd0, done}, 32'd0);
        chk("idle_after_done", {31'd0, cmd_ready}, 32'd1);
      end
    end

    // Reset during the third beat of a length-8 burst.
    out_ready  = 1'b1;
    cmd_valid  = 1'b1;
    cmd_addr   = 6'd0;
    cmd_length = 7'd8;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    step();
    chk("mid_reset_third_beat", out_data, ram[2]);
    resetn = 1'b0;
    step();
    chk("mid_reset_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_reset_busy", {31'd0, busy}, 32'd0);
    chk("mid_reset_done", {31'd0, done}, 32'd0);
    chk("mid_reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    resetn = 1'b1;
    step();
    chk("no_done_after_reset", {31'd0, done}, 32'd0);
    run_burst(6'd0, 7'd2, 0, 3, 1'b0, 6'd0, 7'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
